// File: rtl/pipe_stage_skid_reg_pkg.sv
// pipe_stage_skid_reg_pkg: shared state encodings and default widths for the skid pipeline register
package pipe_stage_skid_reg_pkg;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL = 2'd1;
  localparam logic [1:0] ST_SKID = 2'd2;
  localparam int DEF_DATA_W = 10;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/pipe_stage_skid_reg_sat_counter.sv
// sat_counter: saturating up-counter with synchronous active-low clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             INC,
  output logic [CNT_W-1:0] CNT
);
  always_ff @(posedge CLK) begin
    if (!RST_N) CNT <= '0;
    else if (INC && !(&CNT)) CNT <= CNT + CNT_W'(1);
  end
endmodule

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: valid/ready pipeline register with one-entry skid buffer and flush.
// Define PIPE_STAGE_PERF_EN to build the saturating STALL_CNT/FLUSH_CNT counters.
module pipe_stage_skid_reg
  import pipe_stage_skid_reg_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] DATA_OUT,
  input  logic              FLUSH,
  output logic [CNT_W-1:0]  STALL_CNT,
  output logic [CNT_W-1:0]  FLUSH_CNT
);
  logic [1:0] state, state_nxt;
  logic [DATA_W-1:0] main_q, skid_q;
  logic in_fire, load_main, load_skid;
  assign IN_READY = (state != ST_SKID) && RST_N;
  assign OUT_VALID = (state != ST_EMPTY) && RST_N;
  assign DATA_OUT = main_q;
  assign in_fire = IN_VALID && IN_READY;
  // main takes new input when it is free or draining; skid refills main on drain
  assign load_main = (in_fire && (state == ST_EMPTY || OUT_READY)) || (state == ST_SKID && OUT_READY);
  assign load_skid = in_fire && state == ST_FULL && !OUT_READY;
  always_comb begin
    state_nxt = state == ST_EMPTY ? (in_fire ? ST_FULL : ST_EMPTY) :
                state == ST_FULL  ? (in_fire ? (OUT_READY ? ST_FULL : ST_SKID) : (OUT_READY ? ST_EMPTY : ST_FULL)) :
                state == ST_SKID  ? (OUT_READY ? ST_FULL : ST_SKID) : ST_EMPTY;
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= ST_EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      state <= FLUSH ? ST_EMPTY : state_nxt;
      if (!FLUSH && load_main) main_q <= state == ST_SKID ? skid_q : DATA_IN;
      if (!FLUSH && load_skid) skid_q <= DATA_IN;
    end
  end
`ifdef PIPE_STAGE_PERF_EN
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK(CLK), .RST_N(RST_N), .INC(OUT_VALID && !OUT_READY && !FLUSH), .CNT(STALL_CNT)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK(CLK), .RST_N(RST_N), .INC(FLUSH && state != ST_EMPTY), .CNT(FLUSH_CNT)
  );
`else
  assign STALL_CNT = '0;
  assign FLUSH_CNT = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg: directed + randomized bench against a queue-based model of the skid stage
module tb_pipe_stage_skid_reg;
  localparam int DW = 10;
  localparam int CW = 4;
  localparam logic [DW-1:0] RV = 10'h155;
  localparam int CMAX = (1 << CW) - 1;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic in_ready, out_valid;
  logic [DW-1:0] data_out;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_last;
  int m_stall, m_flush;
  bit m_init = 1'b0;
  pipe_stage_skid_reg #(.DATA_W(DW), .RESET_VAL(RV), .CNT_W(CW)) dut (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready), .DATA_IN(data_in),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .DATA_OUT(data_out), .FLUSH(flush),
    .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt)
  );
  always #5 clk = ~clk;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endfunction
  // model: the stage is a FIFO of depth 2; DATA_OUT shows the head, or the last head once empty
  always @(posedge clk) begin
    bit do_in, do_out;
    if (!rst_n) begin
      mq.delete();
      m_last = RV;
      m_stall = 0;
      m_flush = 0;
      m_init = 1'b1;
    end else if (m_init) begin
      do_in = in_valid && mq.size() < 2;
      do_out = mq.size() > 0 && out_ready;
      if (mq.size() > 0 && !out_ready && !flush && m_stall < CMAX) m_stall++;
      if (flush && mq.size() > 0 && m_flush < CMAX) m_flush++;
      if (flush) mq.delete();
      else begin
        if (do_out) void'(mq.pop_front());
        if (do_in) mq.push_back(data_in);
      end
      if (mq.size() > 0) m_last = mq[0];
    end
  end
  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready", 32'(in_ready), 32'(rst_n && mq.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(rst_n && mq.size() > 0));
      chk("data_out", 32'(data_out), 32'(mq.size() > 0 ? mq[0] : m_last));
      chk("stall_cnt", 32'(stall_cnt), PERF ? 32'(m_stall) : 32'd0);
      chk("flush_cnt", 32'(flush_cnt), PERF ? 32'(m_flush) : 32'd0);
      chk("no_3ff_out", 32'(out_valid && data_out == 10'h3FF), 32'd0);
    end
  end
  task automatic settle();
    @(negedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; in_valid = 1'b1; data_in = 10'h123;
    repeat (2) @(posedge clk);
    settle();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'(RV));
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_release_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      data_in = DW'(i); in_valid = 1'b1;
      settle();
      chk("stream_data", 32'(data_out), 32'(i));
      chk("stream_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    settle();
    chk("stream_drained", 32'(out_valid), 32'd0);
    chk("stream_last", 32'(data_out), 32'h010);
    out_ready = 1'b0; in_valid = 1'b1; data_in = 10'h0A1;
    settle();
    data_in = 10'h0A2;
    settle();
    in_valid = 1'b0;
    chk("skid_in_ready", 32'(in_ready), 32'd0);
    chk("skid_out_valid", 32'(out_valid), 32'd1);
    chk("skid_head", 32'(data_out), 32'h0A1);
    settle();
    chk("skid_held", 32'(data_out), 32'h0A1);
    out_ready = 1'b1;
    settle();
    chk("skid_second", 32'(data_out), 32'h0A2);
    chk("skid_ready_again", 32'(in_ready), 32'd1);
    settle();
    chk("skid_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0; in_valid = 1'b1; data_in = 10'h0B1;
    settle();
    data_in = 10'h0B2;
    settle();
    chk("flush_pre_skid", 32'(in_ready), 32'd0);
    flush = 1'b1; data_in = 10'h3FF;
    settle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_skid_valid", 32'(out_valid), 32'd0);
    chk("flush_skid_ready", 32'(in_ready), 32'd1);
    chk("flush_data_kept", 32'(data_out), 32'h0B1);
    chk("flush_cnt_1", 32'(flush_cnt), PERF ? 32'd1 : 32'd0);
    out_ready = 1'b1;
    repeat (3) settle();
    chk("flush_stays_empty", 32'(out_valid), 32'd0);
    in_valid = 1'b1; data_in = 10'h0C1;
    settle();
    flush = 1'b1; data_in = 10'h3FF; out_ready = 1'b0;
    settle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_full_valid", 32'(out_valid), 32'd0);
    chk("flush_full_data", 32'(data_out), 32'h0C1);
    chk("flush_cnt_2", 32'(flush_cnt), PERF ? 32'd2 : 32'd0);
    flush = 1'b1;
    settle();
    flush = 1'b0;
    chk("flush_empty_valid", 32'(out_valid), 32'd0);
    chk("flush_empty_cnt", 32'(flush_cnt), PERF ? 32'd2 : 32'd0);
    in_valid = 1'b1; data_in = 10'h0D1;
    settle();
    in_valid = 1'b0;
    repeat (20) settle();
    chk("stall_sat", 32'(stall_cnt), PERF ? 32'd15 : 32'd0);
    chk("stall_data", 32'(data_out), 32'h0D1);
    out_ready = 1'b1;
    settle();
    chk("stall_drained", 32'(out_valid), 32'd0);
    repeat (600) begin
      rst_n = $urandom_range(0, 99) != 0;
      in_valid = 1'($urandom_range(0, 1));
      data_in = DW'($urandom_range(0, 10'h3FE));
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 19) == 0;
      settle();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
